// File: rtl/cluster_event_dispatcher_if.sv
// Bundle of the dispatcher's event, wait handshake and status signals.
// The master side belongs to the control unit and cores; the slave side belongs to the dispatcher.
interface cluster_event_dispatcher_if #(
    parameter int CORE_NUM  = 4,
    parameter int CNT_WIDTH = 4
);
    logic                          event_i;
    logic [CORE_NUM-1:0]           fetch_en_i;
    logic [CORE_NUM-1:0]           event_mask_i;
    logic [CORE_NUM-1:0]           wait_req_i;
    logic                          overflow_clr_i;
    logic [CORE_NUM-1:0]           wait_ack_o;
    logic [CORE_NUM-1:0]           clock_en_o;
    logic [CORE_NUM-1:0]           sleeping_o;
    logic [CORE_NUM*CNT_WIDTH-1:0] pending_cnt_o;
    logic [CORE_NUM-1:0]           overflow_o;

    modport master (
        output event_i, fetch_en_i, event_mask_i, wait_req_i, overflow_clr_i,
        input  wait_ack_o, clock_en_o, sleeping_o, pending_cnt_o, overflow_o
    );

    modport slave (
        input  event_i, fetch_en_i, event_mask_i, wait_req_i, overflow_clr_i,
        output wait_ack_o, clock_en_o, sleeping_o, pending_cnt_o, overflow_o
    );
endinterface

// File: rtl/cluster_event_dispatcher.sv
// Per-core software-event dispatcher: saturating pending-event counters and a
// RUN/SLEEP/WAKE wait FSM per core that gates the core clock while it waits.
module cluster_event_dispatcher #(
    parameter int CORE_NUM  = 4,
    parameter int CNT_WIDTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    cluster_event_dispatcher_if.slave   bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SLEEP = 2'd1,
        WAKE  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               state_q [CORE_NUM];
    state_t               state_d [CORE_NUM];
    logic [CNT_WIDTH-1:0] cnt_q   [CORE_NUM];
    logic [CNT_WIDTH-1:0] cnt_d   [CORE_NUM];
    logic [CORE_NUM-1:0]  ack_q, ack_d;
    logic [CORE_NUM-1:0]  ovf_q, ovf_d;

    logic [CORE_NUM-1:0]  ev;
    logic [CORE_NUM-1:0]  req;
    logic [CORE_NUM-1:0]  inc;
    logic [CORE_NUM-1:0]  dec;

    logic [CORE_NUM-1:0]           clock_en;
    logic [CORE_NUM-1:0]           sleeping;
    logic [CORE_NUM*CNT_WIDTH-1:0] cnt_flat;

    assign ev  = {CORE_NUM{bus.event_i}} & bus.event_mask_i & bus.fetch_en_i;
    // A request still held during its own ack cycle must not start a second wait.
    assign req = bus.wait_req_i & bus.fetch_en_i & ~ack_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < CORE_NUM; c++) begin
                state_q[c] <= RUN;
                cnt_q[c]   <= '0;
            end
            ack_q <= '0;
            ovf_q <= '0;
        end else begin
            for (int c = 0; c < CORE_NUM; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
            ack_q <= ack_d;
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        inc     = '0;
        dec     = '0;
        ovf_d   = ovf_q & ~{CORE_NUM{bus.overflow_clr_i}};
        for (int c = 0; c < CORE_NUM; c++) begin
            unique case (state_q[c])
                RUN: begin
                    if (req[c]) begin
                        // An event coinciding with the request is consumed directly.
                        if (ev[c] || cnt_q[c] != '0) begin
                            ack_d[c] = 1'b1;
                            inc[c]   = ev[c];
                            dec[c]   = 1'b1;
                        end else begin
                            state_d[c] = SLEEP;
                        end
                    end else begin
                        inc[c] = ev[c];
                    end
                end
                SLEEP: begin
                    if (ev[c]) begin
                        state_d[c] = WAKE;
                        ack_d[c]   = 1'b1;
                    end
                end
                WAKE: begin
                    state_d[c] = RUN;
                    inc[c]     = ev[c];
                end
                default: state_d[c] = RUN;
            endcase

            if (inc[c] && !dec[c]) begin
                if (cnt_q[c] == CNT_MAX) begin
                    ovf_d[c] = 1'b1;
                end else begin
                    cnt_d[c] = cnt_q[c] + 1'b1;
                end
            end else if (dec[c] && !inc[c]) begin
                cnt_d[c] = cnt_q[c] - 1'b1;
            end

            // A core with fetch disabled is parked in RUN with an empty counter.
            if (!bus.fetch_en_i[c]) begin
                state_d[c] = RUN;
                cnt_d[c]   = '0;
                ack_d[c]   = 1'b0;
            end
        end
    end

    always_comb begin
        clock_en = '0;
        sleeping = '0;
        cnt_flat = '0;
        for (int c = 0; c < CORE_NUM; c++) begin
            clock_en[c]                          = (state_q[c] != SLEEP);
            sleeping[c]                          = (state_q[c] == SLEEP);
            cnt_flat[c*CNT_WIDTH +: CNT_WIDTH]   = cnt_q[c];
        end
    end

    assign bus.wait_ack_o    = ack_q;
    assign bus.clock_en_o    = clock_en;
    assign bus.sleeping_o    = sleeping;
    assign bus.pending_cnt_o = cnt_flat;
    assign bus.overflow_o    = ovf_q;

endmodule

// File: tb/tb_cluster_event_dispatcher.sv
// Directed bench for cluster_event_dispatcher: a vector table for single-cycle
// behaviour plus hand-written saturation and asynchronous-reset sequences.
module tb_cluster_event_dispatcher;

    localparam int CORE_NUM  = 4;
    localparam int CNT_WIDTH = 4;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    cluster_event_dispatcher_if #(.CORE_NUM(CORE_NUM), .CNT_WIDTH(CNT_WIDTH)) bus ();

    cluster_event_dispatcher #(.CORE_NUM(CORE_NUM), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  fetch;
        logic [3:0]  mask;
        logic        ev;
        logic [3:0]  req;
        logic        clr;
        logic [3:0]  ack;
        logic [3:0]  clken;
        logic [3:0]  sleep;
        logic [15:0] cnt;
        logic [3:0]  ovf;
        string       name;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    // Drive one cycle of inputs at the falling edge and return at the next falling edge.
    task automatic applyStimulus(input logic [3:0] fetch, input logic [3:0] mask,
                                 input logic ev, input logic [3:0] req, input logic clr);
        bus.fetch_en_i     = fetch;
        bus.event_mask_i   = mask;
        bus.event_i        = ev;
        bus.wait_req_i     = req;
        bus.overflow_clr_i = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [3:0] ack, input logic [3:0] clken,
                               input logic [3:0] sleep, input logic [15:0] cnt, input logic [3:0] ovf);
        tests_run++;
        if (bus.wait_ack_o !== ack || bus.clock_en_o !== clken || bus.sleeping_o !== sleep ||
            bus.pending_cnt_o !== cnt || bus.overflow_o !== ovf) begin
            tests_failed++;
            $display("[TB] FAIL %s: got ack=%h clken=%h sleep=%h cnt=%h ovf=%h, expected ack=%h clken=%h sleep=%h cnt=%h ovf=%h",
                     name, bus.wait_ack_o, bus.clock_en_o, bus.sleeping_o, bus.pending_cnt_o, bus.overflow_o,
                     ack, clken, sleep, cnt, ovf);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        //            fetch  mask  ev    req   clr     ack   clken sleep cnt       ovf
        vecs[0]  = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 16'h0000, 4'h0, "reset_idle"};
        vecs[1]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 16'h1111, 4'h0, "event_1"};
        vecs[2]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 16'h2222, 4'h0, "event_2"};
        vecs[3]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 16'h3333, 4'h0, "event_3"};
        vecs[4]  = '{4'hF, 4'hF, 1'b0, 4'h1, 1'b0, 4'h1, 4'hF, 4'h0, 16'h3332, 4'h0, "core0_ack"};
        vecs[5]  = '{4'hF, 4'hF, 1'b0, 4'h1, 1'b0, 4'h0, 4'hF, 4'h0, 16'h3332, 4'h0, "core0_req_in_ack"};
        vecs[6]  = '{4'h0, 4'hF, 1'b0, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 16'h0000, 4'h0, "fetch_clear"};
        vecs[7]  = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 16'h0000, 4'h0, "idle"};
        vecs[8]  = '{4'hF, 4'hF, 1'b0, 4'h2, 1'b0, 4'h0, 4'hD, 4'h2, 16'h0000, 4'h0, "core1_sleep"};
        vecs[9]  = '{4'hF, 4'hF, 1'b0, 4'h2, 1'b0, 4'h0, 4'hD, 4'h2, 16'h0000, 4'h0, "core1_asleep"};
        vecs[10] = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b0, 4'h2, 4'hF, 4'h0, 16'h1101, 4'h0, "core1_wake"};
        vecs[11] = '{4'hF, 4'hF, 1'b0, 4'h2, 1'b0, 4'h0, 4'hF, 4'h0, 16'h1101, 4'h0, "core1_req_in_ack"};
        vecs[12] = '{4'h0, 4'hF, 1'b0, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 16'h0000, 4'h0, "fetch_clear2"};
        vecs[13] = '{4'hF, 4'h4, 1'b1, 4'h4, 1'b0, 4'h4, 4'hF, 4'h0, 16'h0000, 4'h0, "core2_req_ev_at0"};
        vecs[14] = '{4'hF, 4'h4, 1'b0, 4'h4, 1'b0, 4'h0, 4'hF, 4'h0, 16'h0000, 4'h0, "core2_req_in_ack"};
        vecs[15] = '{4'hF, 4'h4, 1'b1, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 16'h0100, 4'h0, "core2_event"};
        vecs[16] = '{4'hF, 4'h4, 1'b1, 4'h4, 1'b0, 4'h4, 4'hF, 4'h0, 16'h0100, 4'h0, "core2_req_ev_at1"};
        vecs[17] = '{4'hF, 4'h4, 1'b0, 4'h4, 1'b0, 4'h0, 4'hF, 4'h0, 16'h0100, 4'h0, "core2_req_in_ack2"};
        vecs[18] = '{4'h0, 4'hF, 1'b0, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 16'h0000, 4'h0, "fetch_clear3"};
        vecs[19] = '{4'hF, 4'h5, 1'b1, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 16'h0101, 4'h0, "mask_0101"};
        vecs[20] = '{4'hF, 4'hF, 1'b0, 4'h8, 1'b0, 4'h0, 4'h7, 4'h8, 16'h0101, 4'h0, "core3_sleep"};
        vecs[21] = '{4'h7, 4'hF, 1'b0, 4'h8, 1'b0, 4'h0, 4'hF, 4'h0, 16'h0101, 4'h0, "core3_fetch_drop"};
        vecs[22] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 4'h0, 4'hF, 4'h0, 16'h0101, 4'h0, "core3_run"};

        rst_n              = 1'b0;
        bus.fetch_en_i     = 4'hF;
        bus.event_mask_i   = 4'hF;
        bus.event_i        = 1'b0;
        bus.wait_req_i     = 4'h0;
        bus.overflow_clr_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("in_reset", 4'h0, 4'hF, 4'h0, 16'h0000, 4'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].fetch, vecs[i].mask, vecs[i].ev, vecs[i].req, vecs[i].clr);
            checkOutput(vecs[i].name, vecs[i].ack, vecs[i].clken, vecs[i].sleep, vecs[i].cnt, vecs[i].ovf);
        end

        // Saturation on core 0: 15 events fill the counter, the 16th is lost.
        applyStimulus(4'h0, 4'h1, 1'b0, 4'h0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(4'hF, 4'h1, 1'b1, 4'h0, 1'b0);
            if (i == 15) checkOutput("sat_at_15", 4'h0, 4'hF, 4'h0, 16'h000F, 4'h0);
            if (i == 16) checkOutput("sat_overflow", 4'h0, 4'hF, 4'h0, 16'h000F, 4'h1);
        end
        applyStimulus(4'hF, 4'h1, 1'b1, 4'h0, 1'b1);
        checkOutput("clr_with_overflow", 4'h0, 4'hF, 4'h0, 16'h000F, 4'h1);
        applyStimulus(4'hF, 4'h1, 1'b0, 4'h0, 1'b1);
        checkOutput("clr_alone", 4'h0, 4'hF, 4'h0, 16'h000F, 4'h0);
        applyStimulus(4'hF, 4'h1, 1'b1, 4'h0, 1'b0);
        checkOutput("overflow_again", 4'h0, 4'hF, 4'h0, 16'h000F, 4'h1);
        applyStimulus(4'h0, 4'h1, 1'b0, 4'h0, 1'b0);
        checkOutput("fetch_keeps_ovf", 4'h0, 4'hF, 4'h0, 16'h0000, 4'h1);

        // Core 0 asleep with other counters nonzero, then reset between clock edges.
        applyStimulus(4'hF, 4'hE, 1'b1, 4'h0, 1'b0);
        checkOutput("pre_reset_events", 4'h0, 4'hF, 4'h0, 16'h1110, 4'h1);
        applyStimulus(4'hF, 4'hE, 1'b0, 4'h1, 1'b0);
        checkOutput("core0_sleep", 4'h0, 4'hE, 4'h1, 16'h1110, 4'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 4'h0, 4'hF, 4'h0, 16'h0000, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'hF, 4'hF, 1'b0, 4'h0, 1'b0);
        checkOutput("post_reset_idle", 4'h0, 4'hF, 4'h0, 16'h0000, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
